// File: rtl/jt51_timer_pkg.sv
// Shared constants for the jt51 timer register front end:
// register addresses and the bit positions inside the timer control register.
package jt51_timer_pkg;

  // Register addresses
  localparam logic [7:0] REG_CLKA1 = 8'h10;
  localparam logic [7:0] REG_CLKA2 = 8'h11;
  localparam logic [7:0] REG_CLKB  = 8'h12;
  localparam logic [7:0] REG_TCTRL = 8'h14;

  // Bit indices inside REG_TCTRL
  localparam int unsigned CSM     = 7;
  localparam int unsigned RST_B   = 5;
  localparam int unsigned RST_A   = 4;
  localparam int unsigned IRQEN_B = 3;
  localparam int unsigned IRQEN_A = 2;
  localparam int unsigned LOAD_B  = 1;
  localparam int unsigned LOAD_A  = 0;

endpackage

// File: rtl/jt51_busy_cnt.sv
// Write busy counter: loads BUSY_CEN on start, counts down once per cen.
// Ports: clk, rst_n (sync, active low), cen (count enable), start (load),
//        busy (count != 0).
module jt51_busy_cnt #(
  parameter int unsigned BUSY_CEN = 64,
  parameter int unsigned BUSY_W   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic start,
  output logic busy
);

  logic [BUSY_W-1:0] cnt_q;
  logic [BUSY_W-1:0] cnt_d;

  // Start wins over a coincident cen, so the full window is always counted
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = BUSY_W'(BUSY_CEN);
    end else if (cen && (cnt_q != '0)) begin
      cnt_d = cnt_q - BUSY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/jt51_timer_regs.sv
// CPU-side register front end for the jt51 timer pair.
// Decodes the two-phase bus (a0=0 address, a0=1 data), holds registers
// 0x10/0x11/0x12/0x14 and drives the timer block controls.
// Ports: bus (cs_n, wr_n, a0, din), status byte dout, timer inputs
//        (flag_A/B, overflow_A, cen, zero), timer controls (value_A/B,
//        load_A/B, enable_irq_A/B, clr_flag_A/B), csm, csm_kon, busy.
module jt51_timer_regs #(
  parameter int unsigned BUSY_CEN = 64,
  parameter int unsigned BUSY_W   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       csm,
  output logic       csm_kon,
  output logic       busy
);

  import jt51_timer_pkg::*;

  logic       wr_stb_q;
  logic [7:0] addr_q,    addr_d;
  logic [9:0] value_a_q, value_a_d;
  logic [7:0] value_b_q, value_b_d;
  logic       load_a_q,  load_a_d;
  logic       load_b_q,  load_b_d;
  logic       irq_a_q,   irq_a_d;
  logic       irq_b_q,   irq_b_d;
  logic       clr_a_q,   clr_a_d;
  logic       clr_b_q,   clr_b_d;
  logic       csm_q,     csm_d;
  logic       kon_q,     kon_d;
  logic [7:0] dout_q,    dout_d;
  logic       wr_stb;
  logic       wr_det;
  logic       data_we;

  // Busy is a level from the counter; a data write is only accepted while idle
  jt51_busy_cnt #(
    .BUSY_CEN (BUSY_CEN),
    .BUSY_W   (BUSY_W)
  ) u_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .start (data_we),
    .busy  (busy)
  );

  // Strobe edge detect: a held strobe is a single write
  always_comb begin
    wr_stb  = ~cs_n & ~wr_n;
    wr_det  = wr_stb & ~wr_stb_q;
    data_we = wr_det & a0 & ~busy;
  end

  // Next-state decode of the register file
  always_comb begin
    addr_d    = addr_q;
    value_a_d = value_a_q;
    value_b_d = value_b_q;
    load_a_d  = load_a_q;
    load_b_d  = load_b_q;
    irq_a_d   = irq_a_q;
    irq_b_d   = irq_b_q;
    csm_d     = csm_q;
    clr_a_d   = 1'b0;
    clr_b_d   = 1'b0;
    dout_d    = {busy, 5'b0, flag_B, flag_A};
    kon_d     = csm_q & overflow_A & cen & zero;

    if (wr_det && !a0) begin
      addr_d = din;
    end

    if (data_we) begin
      case (addr_q)
        REG_CLKA1: value_a_d[9:2] = din;
        REG_CLKA2: value_a_d[1:0] = din[1:0];
        REG_CLKB:  value_b_d      = din;
        REG_TCTRL: begin
          csm_d    = din[CSM];
          irq_b_d  = din[IRQEN_B];
          irq_a_d  = din[IRQEN_A];
          load_b_d = din[LOAD_B];
          load_a_d = din[LOAD_A];
          clr_b_d  = din[RST_B];
          clr_a_d  = din[RST_A];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_stb_q  <= 1'b0;
      addr_q    <= '0;
      value_a_q <= '0;
      value_b_q <= '0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      irq_a_q   <= 1'b0;
      irq_b_q   <= 1'b0;
      clr_a_q   <= 1'b0;
      clr_b_q   <= 1'b0;
      csm_q     <= 1'b0;
      kon_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_stb_q  <= wr_stb;
      addr_q    <= addr_d;
      value_a_q <= value_a_d;
      value_b_q <= value_b_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      irq_a_q   <= irq_a_d;
      irq_b_q   <= irq_b_d;
      clr_a_q   <= clr_a_d;
      clr_b_q   <= clr_b_d;
      csm_q     <= csm_d;
      kon_q     <= kon_d;
      dout_q    <= dout_d;
    end
  end

  assign value_A      = value_a_q;
  assign value_B      = value_b_q;
  assign load_A       = load_a_q;
  assign load_B       = load_b_q;
  assign enable_irq_A = irq_a_q;
  assign enable_irq_B = irq_b_q;
  assign clr_flag_A   = clr_a_q;
  assign clr_flag_B   = clr_b_q;
  assign csm          = csm_q;
  assign csm_kon      = kon_q;
  assign dout         = dout_q;

endmodule

// File: tb/tb_jt51_timer_regs.sv
// Self-checking bench for jt51_timer_regs: expected values are queued when
// stimulus is driven and compared when the DUT output is sampled.
module tb_jt51_timer_regs;

  logic       clk = 1'b0;
  logic       rst_n, cen, zero, cs_n, wr_n, a0;
  logic [7:0] din;
  logic [7:0] dout;
  logic       flag_A, flag_B, overflow_A;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, enable_irq_A, enable_irq_B;
  logic       clr_flag_A, clr_flag_B, csm, csm_kon, busy;

  always #5 clk = ~clk;

  jt51_timer_regs #(.BUSY_CEN(64), .BUSY_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .cs_n(cs_n),
    .wr_n(wr_n), .a0(a0), .din(din), .dout(dout), .flag_A(flag_A),
    .flag_B(flag_B), .overflow_A(overflow_A), .value_A(value_A),
    .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .csm(csm),
    .csm_kon(csm_kon), .busy(busy)
  );

  localparam int S_VA = 0, S_VB = 1, S_LA = 2, S_LB = 3, S_IA = 4, S_IB = 5;
  localparam int S_CA = 6, S_CB = 7, S_CSM = 8, S_KON = 9, S_BUSY = 10, S_DOUT = 11;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Reference register model
  logic [7:0] m_addr;
  logic [9:0] m_va;
  logic [7:0] m_vb;
  logic       m_la, m_lb, m_ia, m_ib, m_csm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_VA:    return 32'(value_A);
      S_VB:    return 32'(value_B);
      S_LA:    return 32'(load_A);
      S_LB:    return 32'(load_B);
      S_IA:    return 32'(enable_irq_A);
      S_IB:    return 32'(enable_irq_B);
      S_CA:    return 32'(clr_flag_A);
      S_CB:    return 32'(clr_flag_B);
      S_CSM:   return 32'(csm);
      S_KON:   return 32'(csm_kon);
      S_BUSY:  return 32'(busy);
      S_DOUT:  return 32'(dout);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic push_regs(input string tag);
    push({tag, ".value_A"}, S_VA, 32'(m_va));
    push({tag, ".value_B"}, S_VB, 32'(m_vb));
    push({tag, ".load_A"},  S_LA, 32'(m_la));
    push({tag, ".load_B"},  S_LB, 32'(m_lb));
    push({tag, ".irq_A"},   S_IA, 32'(m_ia));
    push({tag, ".irq_B"},   S_IB, 32'(m_ib));
    push({tag, ".csm"},     S_CSM, 32'(m_csm));
  endtask

  // cen runs every 4th clk throughout
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cen = (cyc % 4 == 0);
  endtask

  task automatic model_reset();
    m_addr = '0; m_va = '0; m_vb = '0;
    m_la = 0; m_lb = 0; m_ia = 0; m_ib = 0; m_csm = 0;
  endtask

  task automatic model_data(input logic [7:0] d, output logic ca, output logic cb);
    ca = 1'b0;
    cb = 1'b0;
    case (m_addr)
      8'h10: m_va[9:2] = d;
      8'h11: m_va[1:0] = d[1:0];
      8'h12: m_vb = d;
      8'h14: begin
        m_csm = d[7]; m_ib = d[3]; m_ia = d[2]; m_lb = d[1]; m_la = d[0];
        cb = d[5]; ca = d[4];
      end
      default: ;
    endcase
  endtask

  task automatic wr_addr(input logic [7:0] a);
    cs_n = 0; wr_n = 0; a0 = 0; din = a;
    tick();
    m_addr = a;
    cs_n = 1; wr_n = 1;
    tick();
  endtask

  task automatic wr_data(input string tag, input logic [7:0] d, input bit accept);
    logic ca, cb;
    cs_n = 0; wr_n = 0; a0 = 1; din = d;
    tick();
    ca = 0; cb = 0;
    if (accept) model_data(d, ca, cb);
    push_regs(tag);
    push({tag, ".clr_A"}, S_CA, 32'(ca));
    push({tag, ".clr_B"}, S_CB, 32'(cb));
    push({tag, ".busy"}, S_BUSY, 32'd1);
    drain();
    cs_n = 1; wr_n = 1;
    tick();
    push({tag, ".clr_A_end"}, S_CA, 32'd0);
    push({tag, ".clr_B_end"}, S_CB, 32'd0);
    drain();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic push_all(input string tag, input logic [7:0] exp_dout);
    push_regs(tag);
    push({tag, ".clr_A"}, S_CA, 32'd0);
    push({tag, ".clr_B"}, S_CB, 32'd0);
    push({tag, ".kon"},   S_KON, 32'd0);
    push({tag, ".busy"},  S_BUSY, 32'd0);
    push({tag, ".dout"},  S_DOUT, 32'(exp_dout));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_cnt, n_cen, na, nb, n_kon;
    logic exp_b, prev_b, prev_fa, prev_fb, kon_exp;

    rst_n = 0; cen = 0; zero = 0; cs_n = 1; wr_n = 1; a0 = 0; din = '0;
    flag_A = 0; flag_B = 0; overflow_A = 0;
    model_reset();

    // Reset and idle
    tick(); tick();
    push_all("rst", 8'h00); drain();
    rst_n = 1;
    tick();
    push_all("idle", 8'h00); drain();

    // value_A split across two registers
    wr_addr(8'h10); wr_data("clka1", 8'hA5, 1); wait_idle("clka1");
    wr_addr(8'h11); wr_data("clka2", 8'h03, 1); wait_idle("clka2");
    check("value_A_297", 32'(value_A), 32'h297);

    // Busy window on an unmapped address, with dout tracking busy and flags
    wr_addr(8'h20);
    cs_n = 0; wr_n = 0; a0 = 1; din = 8'h77;
    prev_b = 0; prev_fa = flag_A; prev_fb = flag_B;
    tick();
    cs_n = 1; wr_n = 1;
    exp_cnt = 64; n_cen = 0;
    for (int i = 0; i < 300; i++) begin
      exp_b = (exp_cnt != 0);
      push("busy_win", S_BUSY, 32'(exp_b));
      push("dout_win", S_DOUT, 32'({prev_b, 5'b0, prev_fb, prev_fa}));
      drain();
      if (exp_b && cen) n_cen++;
      if (cen && exp_cnt > 0) exp_cnt--;
      flag_A = 1'($urandom_range(0, 1));
      flag_B = 1'($urandom_range(0, 1));
      prev_b = exp_b; prev_fa = flag_A; prev_fb = flag_B;
      tick();
    end
    check("busy_cen_count", 32'(n_cen), 32'd64);
    flag_A = 0; flag_B = 0;
    push_regs("unmapped"); drain();

    // Data write while busy is dropped; after busy it lands
    wr_addr(8'h12);
    wr_data("clkb", 8'h5A, 1);
    wr_data("clkb_busy", 8'hC3, 0);
    wait_idle("clkb_busy");
    wr_data("clkb_idle", 8'hC3, 1);
    wait_idle("clkb_idle");

    // Control write with a long-held strobe: one write, one clear pulse each
    wr_addr(8'h14);
    cs_n = 0; wr_n = 0; a0 = 1; din = 8'h3F;
    na = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        logic ca, cb;
        model_data(8'h3F, ca, cb);
        push_regs("tctrl");
        push("tctrl.clr_A", S_CA, 32'(ca));
        push("tctrl.clr_B", S_CB, 32'(cb));
      end else begin
        push("tctrl.clr_A_hold", S_CA, 32'd0);
        push("tctrl.clr_B_hold", S_CB, 32'd0);
      end
      na += int'(clr_flag_A);
      nb += int'(clr_flag_B);
      drain();
    end
    check("clr_A_pulses", 32'(na), 32'd1);
    check("clr_B_pulses", 32'(nb), 32'd1);
    din = 8'h00;
    wait_idle("hold");
    tick(); tick(); tick();
    push_regs("hold_after_busy");
    push("hold_after_busy.busy", S_BUSY, 32'd0);
    drain();
    cs_n = 1; wr_n = 1;
    tick();

    // CSM key-on
    wr_addr(8'h10); wr_data("a_ff", 8'hFF, 1); wait_idle("a_ff");
    wr_addr(8'h11); wr_data("a_03", 8'h03, 1); wait_idle("a_03");
    check("value_A_3ff", 32'(value_A), 32'h3FF);
    wr_addr(8'h14); wr_data("csm_on", 8'h81, 1);
    n_kon = 0;
    for (int i = 0; i < 60; i++) begin
      zero = (i % 3 != 2);
      overflow_A = (i % 5 < 3);
      kon_exp = m_csm & overflow_A & cen & zero;
      push("kon_on", S_KON, 32'(kon_exp));
      tick();
      n_kon += int'(csm_kon);
      drain();
    end
    check("kon_seen", 32'(n_kon > 0), 32'd1);
    zero = 0; overflow_A = 0;
    wait_idle("csm_on");
    wr_addr(8'h14); wr_data("csm_off", 8'h01, 1);
    for (int i = 0; i < 20; i++) begin
      zero = 1; overflow_A = 1;
      push("kon_off", S_KON, 32'd0);
      tick();
      drain();
    end
    zero = 0; overflow_A = 0;
    wait_idle("csm_off");

    // Reset in the middle of a busy window
    wr_addr(8'h14);
    wr_data("pre_rst", 8'h01, 1);
    rst_n = 0;
    tick();
    model_reset();
    push_all("mid_rst", 8'h00); drain();
    rst_n = 1;
    tick();
    // Address latch was cleared, so this data write hits no register
    wr_data("post_rst", 8'h55, 1);
    wait_idle("post_rst");
    push_regs("post_rst_final"); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
